// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO architectural register block fed by the pipelined multiplier.
// It issues MULT/MULTU to the multiplier and tracks products in flight. Each
// product is written into {hi,lo} MUL_LAT cycles after the multiply is accepted.
// It also serves MTHI/MTLO/MFHI/MFLO, which stall while any product is in flight.
//
// Handshake: an op transfers on a rising clk edge where op_valid && op_ready.
// op_ready does not depend on op_valid. op_ready is low during flush.
// It is also low for HI/LO moves while busy. Multiplies and reserved codes are
// otherwise always ready. Once an op is presented, EX holds op_code/op_src
// stable until it transfers.
module hilo_unit #(
  parameter int          MUL_LAT    = 1,
  parameter logic [63:0] RESET_HILO = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_src,
  output logic        op_ready,
  input  logic        flush,
  output logic        mul_en,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;

  logic               is_mul;
  logic               is_move;
  logic               accept;
  logic               retire;
  logic [MUL_LAT-1:0] inflight;
  logic [MUL_LAT-1:0] issue_bit;

  // Decode the op class and form the acceptance / multiplier-capture strobes.
  always_comb begin
    is_mul     = (op_code == OP_MULT) || (op_code == OP_MULTU);
    is_move    = (op_code == OP_MTHI) || (op_code == OP_MTLO) ||
                 (op_code == OP_MFHI) || (op_code == OP_MFLO);
    op_ready   = !flush && (!is_move || !busy);
    accept     = op_valid && op_ready;
    mul_en     = accept && is_mul;
    mul_signed = (op_code == OP_MULT);
  end

  // A newly accepted multiply enters the in-flight tracker at bit 0.
  always_comb begin
    issue_bit    = '0;
    issue_bit[0] = mul_en;
  end

  assign busy   = |inflight;
  assign retire = inflight[MUL_LAT-1];

  // In-flight tracker: one bit per pipeline slot, shifting toward the retire end.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight <= '0;
    end else begin
      inflight <= (inflight << 1) | issue_bit;
    end
  end

  // HI/LO update: a retiring product wins unless flushed. MT writes cannot
  // coincide with a retire because moves stall while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      {hi, lo} <= RESET_HILO;
    end else if (retire && !flush) begin
      {hi, lo} <= mul_result;
    end else if (accept && (op_code == OP_MTHI)) begin
      hi <= op_src;
    end else if (accept && (op_code == OP_MTLO)) begin
      lo <= op_src;
    end
  end

  // MFHI/MFLO read port: registered data, valid for exactly one cycle per read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (accept && (op_code == OP_MFHI)) begin
      rd_valid <= 1'b1;
      rd_data  <= hi;
    end else if (accept && (op_code == OP_MFLO)) begin
      rd_valid <= 1'b1;
      rd_data  <= lo;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule
